multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the single-cycle-derived core; sequences fetch, decode, execute, memory and writeback over several cycles.
- Consumes the instruction decoder's class flags and func3, plus ALU compare flags and instruction/data memory handshakes.
- Drives PC, IR and register-file write enables, memory requests and datapath mux selects.
- Owns the retired-instruction counter and the sticky illegal-instruction trap.

---
 rtl/multicycle_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath
// strobes and selects, and owns the retired-instruction counter and illegal trap.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             is_int_calc,
  input  logic             is_mem_load,
  input  logic             is_mem_store,
  input  logic             is_branch,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic             is_lui,
  input  logic             is_auipc,
  input  logic             is_r_type,
  input  logic [2:0]       func3,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  input  logic             cmp_ltu,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  output logic             illegal,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  // Bit positions in the one-hot class register; lower index wins on decode.
  localparam int C_LOAD   = 0;
  localparam int C_STORE  = 1;
  localparam int C_BRANCH = 2;
  localparam int C_JAL    = 3;
  localparam int C_JALR   = 4;
  localparam int C_LUI    = 5;
  localparam int C_AUIPC  = 6;
  localparam int C_INT    = 7;

  function automatic logic [7:0] class_onehot(input logic [7:0] flags);
    logic [7:0] oh;
    oh = 8'd0;
    for (int i = 7; i >= 0; i--) begin
      if (flags[i]) begin
        oh = 8'd0;
        oh[i] = 1'b1;
      end
    end
    return oh;
  endfunction

  // Returns {legal, taken}; func3 010/011 are not branch encodings.
  function automatic logic [1:0] branch_eval(input logic [2:0] f3, input logic eq,
                                             input logic lt, input logic ltu);
    logic [1:0] res;
    case (f3)
      3'b000:  res = {1'b1, eq};
      3'b001:  res = {1'b1, ~eq};
      3'b100:  res = {1'b1, lt};
      3'b101:  res = {1'b1, ~lt};
      3'b110:  res = {1'b1, ltu};
      3'b111:  res = {1'b1, ~ltu};
      default: res = 2'b00;
    endcase
    return res;
  endfunction

  state_t           state_r, state_nx_s;
  logic [7:0]       cls_r;
  logic             r_type_r;
  logic [2:0]       func3_r;
  logic             illegal_r;
  logic [CNT_W-1:0] instret_r;
  logic             retire_s;
  logic [7:0]       flags_s;
  logic [7:0]       dec_cls_s;
  logic [1:0]       br_s;
  logic             alu_a_cls_s;
  logic             alu_b_cls_s;

  assign flags_s   = {is_int_calc, is_auipc, is_lui, is_jalr, is_jal,
                      is_branch, is_mem_store, is_mem_load};
  assign dec_cls_s = class_onehot(flags_s);
  assign br_s      = branch_eval(func3_r, cmp_eq, cmp_lt, cmp_ltu);

  assign alu_a_cls_s = cls_r[C_AUIPC];
  assign alu_b_cls_s = (cls_r[C_INT] & ~r_type_r) | cls_r[C_LOAD] | cls_r[C_STORE] |
                       cls_r[C_JALR] | cls_r[C_AUIPC];

  assign state_o = state_r;
  assign illegal = illegal_r;
  assign instret = instret_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_nx_s;
  end

  // Instruction class, r-type and func3 captured once per instruction in DECODE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cls_r    <= 8'd0;
      r_type_r <= 1'b0;
      func3_r  <= 3'd0;
    end else if (state_r == S_DECODE) begin
      cls_r    <= dec_cls_s;
      r_type_r <= is_r_type;
      func3_r  <= func3;
    end else begin
      cls_r    <= cls_r;
      r_type_r <= r_type_r;
      func3_r  <= func3_r;
    end
  end

  // Retired-instruction counter and sticky trap flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_r <= {CNT_W{1'b0}};
      illegal_r <= 1'b0;
    end else begin
      if (retire_s) instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
      else          instret_r <= instret_r;
      if (state_nx_s == S_TRAP) illegal_r <= 1'b1;
      else                      illegal_r <= illegal_r;
    end
  end

  // Next-state and datapath controls.
  always_comb begin
    state_nx_s = state_r;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 2'd0;
    rf_we      = 1'b0;
    wb_sel     = 2'd0;
    alu_a_sel  = 1'b0;
    alu_b_sel  = 1'b0;
    retire_s   = 1'b0;
    case (state_r)
      S_IDLE: state_nx_s = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we      = 1'b1;
          state_nx_s = S_DECODE;
        end else begin
          state_nx_s = S_FETCH;
        end
      end
      S_DECODE: begin
        if (dec_cls_s == 8'd0) state_nx_s = S_TRAP;
        else                   state_nx_s = S_EXEC;
      end
      S_EXEC: begin
        alu_a_sel = alu_a_cls_s;
        alu_b_sel = alu_b_cls_s;
        if (cls_r[C_BRANCH]) begin
          if (br_s[1]) begin
            pc_we      = 1'b1;
            pc_sel     = br_s[0] ? 2'd1 : 2'd0;
            retire_s   = 1'b1;
            state_nx_s = S_FETCH;
          end else begin
            state_nx_s = S_TRAP;
          end
        end else if (cls_r[C_LOAD] | cls_r[C_STORE]) begin
          state_nx_s = S_MEM;
        end else if (cls_r != 8'd0) begin
          state_nx_s = S_WB;
        end else begin
          state_nx_s = S_TRAP;
        end
      end
      S_MEM: begin
        alu_a_sel = alu_a_cls_s;
        alu_b_sel = alu_b_cls_s;
        dmem_req  = 1'b1;
        dmem_we   = cls_r[C_STORE];
        if (!dmem_ready) begin
          state_nx_s = S_MEM;
        end else if (cls_r[C_STORE]) begin
          pc_we      = 1'b1;
          retire_s   = 1'b1;
          state_nx_s = S_FETCH;
        end else begin
          state_nx_s = S_WB;
        end
      end
      S_WB: begin
        alu_a_sel  = alu_a_cls_s;
        alu_b_sel  = alu_b_cls_s;
        rf_we      = 1'b1;
        pc_we      = 1'b1;
        retire_s   = 1'b1;
        state_nx_s = S_FETCH;
        if (cls_r[C_LOAD])                    wb_sel = 2'd1;
        else if (cls_r[C_JAL] | cls_r[C_JALR]) wb_sel = 2'd2;
        else if (cls_r[C_LUI])                wb_sel = 2'd3;
        else                                  wb_sel = 2'd0;
        if (cls_r[C_JAL])       pc_sel = 2'd1;
        else if (cls_r[C_JALR]) pc_sel = 2'd2;
        else                    pc_sel = 2'd0;
      end
      S_TRAP: state_nx_s = S_TRAP;
      // Unused encoding: park safely in TRAP.
      default: state_nx_s = S_TRAP;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed and randomized instructions
// compared against an instruction-level reference model.
module tb_multicycle_ctrl;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic is_int_calc = 1'b0, is_mem_load = 1'b0, is_mem_store = 1'b0, is_branch = 1'b0;
  logic is_jal = 1'b0, is_jalr = 1'b0, is_lui = 1'b0, is_auipc = 1'b0, is_r_type = 1'b0;
  logic [2:0] func3 = 3'd0;
  logic cmp_eq = 1'b0, cmp_lt = 1'b0, cmp_ltu = 1'b0;
  logic imem_ready = 1'b0, dmem_ready = 1'b0;
  logic imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, alu_a_sel, alu_b_sel, illegal;
  logic [1:0] pc_sel, wb_sel;
  logic [2:0] state_o;
  logic [CNT_W-1:0] instret;

  int checks = 0;
  int errors = 0;
  int exp_instret = 0;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .is_int_calc(is_int_calc), .is_mem_load(is_mem_load), .is_mem_store(is_mem_store),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .is_lui(is_lui),
    .is_auipc(is_auipc), .is_r_type(is_r_type), .func3(func3),
    .cmp_eq(cmp_eq), .cmp_lt(cmp_lt), .cmp_ltu(cmp_ltu),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .illegal(illegal),
    .state_o(state_o), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Flag bit order: 0 load,1 store,2 branch,3 jal,4 jalr,5 lui,6 auipc,7 int_calc.
  task automatic set_flags(input logic [7:0] fl);
    is_mem_load  = fl[0];
    is_mem_store = fl[1];
    is_branch    = fl[2];
    is_jal       = fl[3];
    is_jalr      = fl[4];
    is_lui       = fl[5];
    is_auipc     = fl[6];
    is_int_calc  = fl[7];
  endtask

  function automatic int class_of(input logic [7:0] fl);
    for (int i = 0; i < 8; i++) if (fl[i]) return i;
    return 8;
  endfunction

  function automatic logic taken_of(input logic [2:0] f3, input logic eq, input logic lt,
                                    input logic ltu);
    case (f3)
      3'd0: return eq;
      3'd1: return !eq;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      default: return !ltu;
    endcase
  endfunction

  function automatic logic [4:0] strobes();
    return {imem_req, dmem_req, ir_we, pc_we, rf_we};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    #1;
    exp_instret = 0;
    chk("rst_state", state_o, 0);
    chk("rst_instret", instret, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_strobes", strobes(), 0);
    chk("rst_selects", {pc_sel, wb_sel, alu_a_sel, alu_b_sel}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one instruction starting in FETCH; stops when FETCH is re-entered or TRAP reached.
  task automatic run_instr(input string tag, input logic [7:0] fl, input logic rt,
                           input logic [2:0] f3, input logic eq, input logic lt,
                           input logic ltu, input int iw, input int dw);
    int cls, n_ir, n_imem, n_dm, we_bad, n_pc, n_rf, ovl_bad, ndiff, c, fc, mc;
    int exp_pc_sel, exp_wb, exp_trace[$], obs_trace[$];
    logic legal, tk, exp_rf, is_mem, exp_a, exp_b, done, left;
    logic [2:0] st;
    logic [1:0] pc_sel_o, wb_o;
    logic a_ex, b_ex, a_wb, b_wb;
    cls    = class_of(fl);
    is_mem = (cls == 0) || (cls == 1);
    tk     = taken_of(f3, eq, lt, ltu);
    legal  = (cls != 8) && !(cls == 2 && (f3 == 3'd2 || f3 == 3'd3));
    exp_rf = legal && cls != 1 && cls != 2;
    exp_pc_sel = (cls == 2) ? int'(tk) : (cls == 3) ? 1 : (cls == 4) ? 2 : 0;
    exp_wb = (cls == 0) ? 1 : (cls == 3 || cls == 4) ? 2 : (cls == 5) ? 3 : 0;
    exp_a  = (cls == 6);
    exp_b  = (cls == 7) ? !rt : (cls == 0 || cls == 1 || cls == 4 || cls == 6);
    for (int i = 0; i <= iw; i++) exp_trace.push_back(1);
    exp_trace.push_back(2);
    if (cls != 8) begin
      exp_trace.push_back(3);
      if (is_mem) for (int i = 0; i <= dw; i++) exp_trace.push_back(4);
      if (legal && cls != 1 && cls != 2) exp_trace.push_back(5);
    end
    n_ir = 0; n_imem = 0; n_dm = 0; we_bad = 0; n_pc = 0; n_rf = 0; ovl_bad = 0;
    c = 0; fc = 0; mc = 0; done = 0; left = 0;
    pc_sel_o = 2'd0; wb_o = 2'd0; a_ex = 0; b_ex = 0; a_wb = 0; b_wb = 0;
    while (!done && c < 64) begin
      @(negedge clk);
      c++;
      st = state_o;
      if ((st == 3'd1 && left) || st == 3'd6) begin
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        done = 1;
      end else begin
        set_flags(fl);
        is_r_type = rt; func3 = f3; cmp_eq = eq; cmp_lt = lt; cmp_ltu = ltu;
        imem_ready = (st == 3'd1) && (fc >= iw);
        dmem_ready = (st == 3'd4) && (mc >= dw);
        #1;
        obs_trace.push_back(int'(st));
        if (st != 3'd1) left = 1;
        if (st == 3'd1) fc++;
        if (st == 3'd4) mc++;
        if (imem_req) n_imem++;
        if (ir_we) n_ir++;
        if (dmem_req) begin
          n_dm++;
          if (dmem_we !== (cls == 1)) we_bad++;
        end
        if (pc_we) begin n_pc++; pc_sel_o = pc_sel; end
        if (rf_we) begin n_rf++; wb_o = wb_sel; a_wb = alu_a_sel; b_wb = alu_b_sel; end
        if (pc_we && rf_we && st != 3'd5) ovl_bad++;
        if (st == 3'd3) begin a_ex = alu_a_sel; b_ex = alu_b_sel; end
      end
    end
    if (!done) chk($sformatf("%s_timeout", tag), 0, 1);
    if (legal) exp_instret = (exp_instret + 1) % (1 << CNT_W);
    ndiff = 0;
    for (int i = 0; i < obs_trace.size() && i < exp_trace.size(); i++)
      if (obs_trace[i] != exp_trace[i]) ndiff++;
    chk($sformatf("%s_cycles", tag), obs_trace.size(), exp_trace.size());
    chk($sformatf("%s_state_seq", tag), ndiff, 0);
    chk($sformatf("%s_ir_we", tag), n_ir, 1);
    chk($sformatf("%s_imem_req", tag), n_imem, iw + 1);
    chk($sformatf("%s_dmem_req", tag), n_dm, (is_mem && cls != 8) ? dw + 1 : 0);
    chk($sformatf("%s_dmem_we", tag), we_bad, 0);
    chk($sformatf("%s_pc_we", tag), n_pc, legal ? 1 : 0);
    chk($sformatf("%s_rf_we", tag), n_rf, exp_rf ? 1 : 0);
    chk($sformatf("%s_overlap", tag), ovl_bad, 0);
    if (legal) chk($sformatf("%s_pc_sel", tag), pc_sel_o, exp_pc_sel);
    if (exp_rf) begin
      chk($sformatf("%s_wb_sel", tag), wb_o, exp_wb);
      if (cls != 3 && cls != 5) chk($sformatf("%s_alu_wb", tag), {a_wb, b_wb}, {exp_a, exp_b});
    end
    if (cls != 8 && cls != 3 && cls != 5)
      chk($sformatf("%s_alu_exec", tag), {a_ex, b_ex}, {exp_a, exp_b});
    #1;
    chk($sformatf("%s_instret", tag), instret, exp_instret);
    chk($sformatf("%s_illegal", tag), illegal, legal ? 0 : 1);
  endtask

  task automatic hold_trap(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("%s_hold_state", tag), state_o, 6);
      chk($sformatf("%s_hold_illegal", tag), illegal, 1);
      chk($sformatf("%s_hold_strobes", tag), strobes(), 0);
      chk($sformatf("%s_hold_instret", tag), instret, exp_instret);
    end
  endtask

  task automatic run_random(input string tag);
    logic [7:0] fl;
    logic [2:0] f3;
    logic [2:0] f3_ok [6];
    f3_ok = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    fl = 8'($urandom_range(1, 255));
    f3 = f3_ok[$urandom_range(0, 5)];
    run_instr(tag, fl, 1'($urandom), f3, 1'($urandom), 1'($urandom), 1'($urandom),
              $urandom_range(0, 2), $urandom_range(0, 2));
  endtask

  initial begin
    logic found;
    do_reset();
    run_instr("add",  8'h80, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr("lw",   8'h01, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 0, 3);
    run_instr("beq",  8'h04, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 0, 0);
    run_instr("bne",  8'h04, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 0, 0);
    run_instr("jalr", 8'h10, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1, 0);
    run_instr("jal",  8'h08, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr("lui",  8'h20, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr("auipc",8'h40, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr("addi", 8'h80, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2, 0);
    run_instr("sw",   8'h02, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 0, 1);
    run_instr("bltu", 8'h04, 1'b0, 3'd6, 1'b0, 1'b1, 1'b1, 0, 0);
    run_instr("prio", 8'hFE, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 40; i++) run_random("rand");

    run_instr("fence", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1, 0);
    hold_trap("fence");
    do_reset();
    run_instr("br010", 8'h04, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 0, 0);
    hold_trap("br010");
    do_reset();

    for (int i = 0; i < 15; i++) run_random("pre");
    chk("wrap_pre", instret, 15);
    run_instr("wrap_sw", 8'h02, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 0, 0);
    chk("wrap_zero", instret, 0);
    run_instr("post_add", 8'h80, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);

    found = 1'b0;
    set_flags(8'h01);
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = (state_o == 3'd4);
      imem_ready = (state_o == 3'd1);
      dmem_ready = 1'b0;
      #1;
    end
    chk("mem_reached", found, 1);
    chk("mem_dmem_req", dmem_req, 1);
    chk("mem_dmem_we", dmem_we, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_dmem_req", dmem_req, 0);
    chk("async_state", state_o, 0);
    chk("async_instret", instret, 0);
    chk("async_strobes", strobes(), 0);
    @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
